// File: rtl/mux_pipe_reg_n.sv
// mux_pipe_reg_n: N-input, WIDTH-bit registered mux slot with stall, flush,
// valid propagation and a sticky trap for out-of-range selects.

// One input lane: passes its word through only when the effective index
// points at it, so the top level can OR all lanes into the picked word.
module mux_pipe_reg_n_lane #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] word,
  input  logic [SEL_W-1:0] eff_idx,
  output logic [WIDTH-1:0] gated
);
  localparam logic [SEL_W-1:0] MY_IDX = SEL_W'(IDX);

  // One-hot gate: at most one lane is non-zero for any eff_idx
  assign gated = (eff_idx == MY_IDX) ? word : '0;
endmodule

module mux_pipe_reg_n #(
  parameter int WIDTH       = 32,
  parameter int NUM_IN      = 4,
  parameter int SEL_W       = $clog2(NUM_IN),
  parameter int DEFAULT_IDX = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH*NUM_IN-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err
);
  // One extra bit so NUM_IN itself is representable when it is a power of two
  localparam logic [SEL_W:0]   N_LIM   = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] DEF_IDX = SEL_W'(DEFAULT_IDX);

  logic                        in_range;
  logic [SEL_W-1:0]            eff_idx;
  logic [NUM_IN-1:0][WIDTH-1:0] gated;
  logic [WIDTH-1:0]            pick;
  logic                        accept;

  // Out-of-range selects fall back to the default input instead of aliasing
  assign in_range = ({1'b0, sel} < N_LIM);
  assign eff_idx  = in_range ? sel : DEF_IDX;
  assign accept   = !flush && !stall;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    mux_pipe_reg_n_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .IDX   (i)
    ) u_lane (
      .word    (in_bus[i*WIDTH +: WIDTH]),
      .eff_idx (eff_idx),
      .gated   (gated[i])
    );
  end

  // AND-OR mux: OR together the gated lanes
  always_comb begin
    pick = '0;
    for (int i = 0; i < NUM_IN; i++) pick |= gated[i];
  end

  // Output slot: flush beats stall; data is captured even without in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
    end else if (flush) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
    end else if (!stall) begin
      out       <= pick;
      out_valid <= in_valid;
      out_sel   <= eff_idx;
    end
  end

  // Sticky error: only accepted valid out-of-range selects set it; set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            sel_err <= 1'b0;
    else if (accept && in_valid && !in_range) sel_err <= 1'b1;
    else if (err_clr)                      sel_err <= 1'b0;
  end
endmodule

// File: tb/tb_mux_pipe_reg_n.sv
// Bench for mux_pipe_reg_n: three instances (4x32, 3x32 with default 1,
// 8x8) exercised by directed steps and a randomized model-checked run.
module tb_mux_pipe_reg_n;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Instance A: NUM_IN=4, WIDTH=32
  logic [127:0] a_bus;
  logic [1:0]   a_sel, a_osel;
  logic         a_vld, a_stall, a_flush, a_clr, a_ovld, a_err;
  logic [31:0]  a_out;

  // Instance B: NUM_IN=3, WIDTH=32, DEFAULT_IDX=1
  logic [95:0]  b_bus;
  logic [1:0]   b_sel, b_osel;
  logic         b_vld, b_stall, b_flush, b_clr, b_ovld, b_err;
  logic [31:0]  b_out;

  // Instance C: NUM_IN=8, WIDTH=8
  logic [63:0]  c_bus;
  logic [2:0]   c_sel, c_osel;
  logic         c_vld, c_stall, c_flush, c_clr, c_ovld, c_err;
  logic [7:0]   c_out;

  mux_pipe_reg_n #(.WIDTH(32), .NUM_IN(4), .DEFAULT_IDX(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_bus(a_bus), .sel(a_sel), .in_valid(a_vld),
    .stall(a_stall), .flush(a_flush), .err_clr(a_clr), .out(a_out),
    .out_valid(a_ovld), .out_sel(a_osel), .sel_err(a_err));

  mux_pipe_reg_n #(.WIDTH(32), .NUM_IN(3), .DEFAULT_IDX(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_bus(b_bus), .sel(b_sel), .in_valid(b_vld),
    .stall(b_stall), .flush(b_flush), .err_clr(b_clr), .out(b_out),
    .out_valid(b_ovld), .out_sel(b_osel), .sel_err(b_err));

  mux_pipe_reg_n #(.WIDTH(8), .NUM_IN(8), .DEFAULT_IDX(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_bus(c_bus), .sel(c_sel), .in_valid(c_vld),
    .stall(c_stall), .flush(c_flush), .err_clr(c_clr), .out(c_out),
    .out_valid(c_ovld), .out_sel(c_osel), .sel_err(c_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] o, input logic v, input logic [1:0] s);
    chk({tag, ".out"}, a_out, o);
    chk({tag, ".valid"}, a_ovld, v);
    chk({tag, ".sel"}, a_osel, s);
  endtask

  task automatic chk_b(input string tag, input logic [31:0] o, input logic v,
                       input logic [1:0] s, input logic e);
    chk({tag, ".out"}, b_out, o);
    chk({tag, ".valid"}, b_ovld, v);
    chk({tag, ".sel"}, b_osel, s);
    chk({tag, ".err"}, b_err, e);
  endtask

  logic [127:0] a_base;
  logic [95:0]  b_base;
  logic [3:0]   vpat;
  int           idx;
  logic [7:0]   m_out;
  logic         m_vld, m_err;
  logic [2:0]   m_sel;

  initial begin
    a_base = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b_base = {32'hB2, 32'hB1, 32'hB0};
    vpat   = 4'b1101;   // in_valid for sel 0..3 in the sweep: 1,0,1,1
    a_bus = '0; a_sel = '0; a_vld = 0; a_stall = 0; a_flush = 0; a_clr = 0;
    b_bus = '0; b_sel = '0; b_vld = 0; b_stall = 0; b_flush = 0; b_clr = 0;
    c_bus = '0; c_sel = '0; c_vld = 0; c_stall = 0; c_flush = 0; c_clr = 0;

    // Reset before any clock edge
    rst_n = 1'b0;
    #2;
    chk_a("rst_a", 32'h0, 1'b0, 2'd0);
    chk("rst_a.err", a_err, 1'b0);
    chk_b("rst_b", 32'h0, 1'b0, 2'd0, 1'b0);
    chk("rst_c.out", c_out, 8'h0);
    tick(); tick();
    rst_n = 1'b1;

    // First accept after reset
    a_bus = a_base; a_sel = 2'd2; a_vld = 1;
    tick();
    chk_a("first", 32'hA2, 1'b1, 2'd2);

    // Sweep sel 0..3 with in_valid pattern; data captured regardless of valid
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s); a_vld = vpat[s];
      tick();
      chk_a($sformatf("sweep%0d", s), 32'hA0 + 32'(s), vpat[s], 2'(s));
    end

    // Stall holds the captured word while inputs churn
    a_bus = {a_base[127:32], 32'hDEADBEEF}; a_sel = 2'd0; a_vld = 1;
    tick();
    chk_a("cap", 32'hDEADBEEF, 1'b1, 2'd0);
    a_stall = 1;
    for (int k = 0; k < 3; k++) begin
      a_bus = {$urandom, $urandom, $urandom, $urandom};
      a_sel = 2'($urandom); a_vld = 1'($urandom);
      tick();
      chk_a($sformatf("stall%0d", k), 32'hDEADBEEF, 1'b1, 2'd0);
    end
    a_flush = 1;
    tick();
    chk_a("stall_flush", 32'h0, 1'b0, 2'd0);

    // Release: next edge takes current inputs
    a_flush = 0; a_stall = 0; a_bus = a_base; a_sel = 2'd3; a_vld = 1;
    tick();
    chk_a("release", 32'hA3, 1'b1, 2'd3);
    chk("a_err_pow2", a_err, 1'b0);

    // Reset asserted mid-stall dominates, asynchronously
    a_stall = 1;
    tick();
    chk_a("hold_pre_rst", 32'hA3, 1'b1, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_a("rst_mid_stall", 32'h0, 1'b0, 2'd0);
    #1 rst_n = 1'b1;
    tick();
    chk_a("stall_after_rst", 32'h0, 1'b0, 2'd0);
    a_stall = 0;
    tick();
    chk_a("accept_after_rst", 32'hA3, 1'b1, 2'd3);
    a_vld = 0;

    // Out-of-range select on 3-input instance, default input 1
    b_bus = b_base;
    b_sel = 2'd3; b_vld = 1; tick(); chk_b("oor", 32'hB1, 1'b1, 2'd1, 1'b1);
    b_sel = 2'd0;            tick(); chk_b("sticky", 32'hB0, 1'b1, 2'd0, 1'b1);
    b_sel = 2'd2; b_clr = 1; tick(); chk_b("clr", 32'hB2, 1'b1, 2'd2, 1'b0);
    b_sel = 2'd3;            tick(); chk_b("set_beats_clr", 32'hB1, 1'b1, 2'd1, 1'b1);
    b_sel = 2'd0; b_vld = 0; tick(); chk_b("clr2", 32'hB0, 1'b0, 2'd0, 1'b0);
    b_clr = 0;
    b_sel = 2'd3; b_vld = 0; tick(); chk_b("mask_invalid", 32'hB1, 1'b0, 2'd1, 1'b0);
    b_sel = 2'd0; b_vld = 1; tick(); chk_b("setup", 32'hB0, 1'b1, 2'd0, 1'b0);
    b_sel = 2'd3; b_stall = 1; tick(); chk_b("mask_stall", 32'hB0, 1'b1, 2'd0, 1'b0);
    b_stall = 0; b_flush = 1; tick(); chk_b("mask_flush", 32'h0, 1'b0, 2'd0, 1'b0);
    b_flush = 0; b_vld = 0;

    // Randomized run on 8x8 instance against a rule-level model
    m_out = c_out; m_vld = c_ovld; m_sel = c_osel; m_err = 1'b0;
    chk("c_pre.out", c_out, 8'h0);
    for (int k = 0; k < 1000; k++) begin
      c_bus   = {$urandom, $urandom};
      c_sel   = 3'($urandom);
      c_vld   = 1'($urandom);
      c_stall = ($urandom_range(0, 4) == 0);
      c_flush = ($urandom_range(0, 8) == 0);
      c_clr   = ($urandom_range(0, 3) == 0);
      if (c_flush) begin
        m_out = '0; m_vld = 0; m_sel = '0;
      end else if (!c_stall) begin
        idx   = (int'(c_sel) < 8) ? int'(c_sel) : 0;
        m_out = 8'((c_bus >> (idx * 8)) & 64'hFF);
        m_vld = c_vld;
        m_sel = 3'(idx);
      end
      if (!c_flush && !c_stall && c_vld && int'(c_sel) >= 8) m_err = 1'b1;
      else if (c_clr) m_err = 1'b0;
      tick();
      chk($sformatf("rnd%0d.out", k), c_out, m_out);
      chk($sformatf("rnd%0d.valid", k), c_ovld, m_vld);
      chk($sformatf("rnd%0d.sel", k), c_osel, m_sel);
      chk($sformatf("rnd%0d.err", k), c_err, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
